// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Bundles the two buses the instruction-memory loader sits between:
//   the incoming program byte stream (valid/ready) and the outgoing
//   instruction-memory write port.
//
//   Stream signals:
//     in_valid  source -> loader   in_data holds a valid byte
//     in_data   source -> loader   program byte
//     in_ready  loader -> source   loader accepts a byte this cycle
//   Memory write signals:
//     we        loader -> memory   one-cycle write pulse per word
//     waddr     loader -> memory   word address (ADDR_W bits)
//     wdata     loader -> memory   32-bit instruction word
//
//   Modports:
//     master  the environment side (byte source and memory)
//     slave   the loader itself
interface imem_loader_if #(
  parameter int ADDR_W = 6
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  we,
    input  waddr,
    input  wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output we,
    output waddr,
    output wdata
  );

endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Fills the 64 x 32-bit instruction memory from a byte stream. Four
//   bytes are packed MSB first into each word, and words are written to
//   consecutive addresses starting at 0. The core is held in reset for
//   the whole load and released once the last word has been written.
//
//   Ports:
//     clk        system clock, all state changes on the rising edge
//     reset      synchronous, active-low reset
//     start      begin a load (honoured only when idle or done)
//     nwords     number of words to load, clamped to DEPTH
//     bus        slave side of imem_loader_if (byte stream in,
//                instruction-memory write port out)
//     busy       a load is in progress
//     done       last load completed, sticky until the next start
//     cpu_reset  active-low reset to the core (0 holds it in reset)
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   nwords,
  imem_loader_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic              cpu_reset
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   word_cnt;
  logic [1:0]        byte_cnt;

  logic              in_ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              cpu_reset_q;

  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W:0]   word_cnt_next;
  logic              byte_accept;

  // Oversized requests are clamped so a single load can never wrap
  // around and overwrite address 0.
  assign len_clamped   = (nwords > DEPTH_W) ? DEPTH_W : nwords;
  assign word_cnt_next = word_cnt + 1'b1;
  assign byte_accept   = bus.in_valid && in_ready_q;

  // Every output is a register so the memory and the core see clean,
  // glitch-free signals; this block only forwards them.
  assign bus.in_ready = in_ready_q;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cpu_reset    = cpu_reset_q;

  // Main loader state machine. IDLE and DONE share the start handling,
  // so a new load from DONE behaves exactly like one from IDLE. Bytes
  // shift into wdata from the bottom, leaving the first byte of a word
  // in bits [31:24] after four accepts. WRITE lasts exactly one cycle,
  // with waddr/wdata held stable while we is high; the address advance
  // happens on the edge that leaves WRITE. Reset discards any partial
  // word and keeps the core in reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      len         <= '0;
      word_cnt    <= '0;
      byte_cnt    <= '0;
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cpu_reset_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (nwords == '0) begin
              state       <= S_DONE;
              in_ready_q  <= 1'b0;
              we_q        <= 1'b0;
              waddr_q     <= '0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b1;
            end else begin
              state       <= S_COLLECT;
              len         <= len_clamped;
              word_cnt    <= '0;
              byte_cnt    <= '0;
              in_ready_q  <= 1'b1;
              we_q        <= 1'b0;
              waddr_q     <= '0;
              busy_q      <= 1'b1;
              done_q      <= 1'b0;
              cpu_reset_q <= 1'b0;
            end
          end
        end

        S_COLLECT: begin
          if (byte_accept) begin
            wdata_q  <= {wdata_q[23:0], bus.in_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state      <= S_WRITE;
              in_ready_q <= 1'b0;
              we_q       <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          we_q     <= 1'b0;
          word_cnt <= word_cnt_next;
          if (word_cnt_next == len) begin
            state       <= S_DONE;
            waddr_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b1;
          end else begin
            state      <= S_COLLECT;
            waddr_q    <= waddr_q + 1'b1;
            byte_cnt   <= '0;
            in_ready_q <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Self-checking bench for imem_loader. A transaction-level model tracks
//   how many words and bytes of the current load have been taken and
//   predicts every output each cycle; a few literal expectations pin the
//   model to hand-computed values.
module tb_imem_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   nwords = '0;
  logic              busy;
  logic              done;
  logic              cpu_reset;

  imem_loader_if #(.ADDR_W(ADDR_W)) ifc ();

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .nwords    (nwords),
    .bus       (ifc),
    .busy      (busy),
    .done      (done),
    .cpu_reset (cpu_reset)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  bit chk_en       = 1'b0;

  // Reference model: a load is just "m_len words, each made of four
  // accepted bytes, followed by one write cycle".
  bit          m_loading = 1'b0;
  bit          m_done    = 1'b0;
  int          m_len     = 0;
  int          m_words   = 0;
  int          m_bytes   = 0;
  logic [31:0] m_word    = '0;

  always @(posedge clk) begin
    if (!reset) begin
      m_loading <= 1'b0;
      m_done    <= 1'b0;
      m_words   <= 0;
      m_bytes   <= 0;
      m_word    <= '0;
    end else if (m_loading) begin
      if (m_bytes == 4) begin
        m_words <= m_words + 1;
        if (m_words + 1 == m_len) begin
          m_loading <= 1'b0;
          m_done    <= 1'b1;
        end else begin
          m_bytes <= 0;
        end
      end else if (ifc.in_valid === 1'b1) begin
        m_word  <= m_word * 32'd256 + {24'd0, ifc.in_data};
        m_bytes <= m_bytes + 1;
      end
    end else if (start) begin
      if (nwords == '0) begin
        m_done <= 1'b1;
      end else begin
        m_loading <= 1'b1;
        m_done    <= 1'b0;
        m_len     <= (int'(nwords) > DEPTH) ? DEPTH : int'(nwords);
        m_words   <= 0;
        m_bytes   <= 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("in_ready",  32'(ifc.in_ready), 32'(m_loading && m_bytes < 4));
      checkOutput("we",        32'(ifc.we),       32'(m_loading && m_bytes == 4));
      checkOutput("waddr",     32'(ifc.waddr),    m_loading ? 32'(m_words % DEPTH) : 32'd0);
      checkOutput("busy",      32'(busy),         32'(m_loading));
      checkOutput("done",      32'(done),         32'(m_done));
      checkOutput("cpu_reset", 32'(cpu_reset),    32'(m_done));
      if (m_loading && m_bytes == 4) begin
        checkOutput("wdata", ifc.wdata, m_word);
      end
    end
  end

  // Image of what the memory has been written with, for literal checks.
  logic [31:0] obs_mem [DEPTH];
  int          we_count = 0;

  always @(negedge clk) begin
    if (ifc.we === 1'b1) begin
      obs_mem[ifc.waddr] = ifc.wdata;
      we_count++;
    end
  end

  task automatic pulseStart(input int n);
    @(negedge clk);
    start  = 1'b1;
    nwords = (ADDR_W + 1)'(n);
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Offers bytes until 'count' have been accepted or the cycle budget
  // runs out. mode 0: valid every cycle, 1: toggled 1,0,1,0, 2: random.
  // Bytes are base, base+step, ... unless rnd is set. A start pulse can
  // be injected at cycle start_at to probe that it is ignored.
  task automatic applyStimulus(input int count, input int mode,
                               input logic [7:0] base, input logic [7:0] step,
                               input bit rnd, input int budget,
                               input int start_at, output int accepted);
    int cyc;
    bit v;
    logic [7:0] b;
    cyc = 0;
    accepted = 0;
    b = rnd ? 8'($urandom) : base;
    while (accepted < count && cyc < budget) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      start = (cyc == start_at);
      if (cyc == start_at) nwords = (ADDR_W + 1)'($urandom_range(1, DEPTH));
      ifc.in_valid = v;
      ifc.in_data  = b;
      if (v && ifc.in_ready === 1'b1) begin
        accepted++;
        b = rnd ? 8'($urandom) : 8'(b + step);
      end
      cyc++;
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int c;
    c = 0;
    while (done !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    checkOutput(name, 32'(done), 32'd1);
  endtask

  task automatic holdReset(input int cycles);
    reset = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int w0;

    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'h5A;
    reset        = 1'b0;
    start        = 1'b1;
    nwords       = 7'd1;

    // Reset held with start and in_valid active must leave all outputs low.
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready",  32'(ifc.in_ready), 32'd0);
    checkOutput("rst_we",        32'(ifc.we),       32'd0);
    checkOutput("rst_wdata",     ifc.wdata,         32'd0);
    checkOutput("rst_busy",      32'(busy),         32'd0);
    checkOutput("rst_cpu_reset", 32'(cpu_reset),    32'd0);
    @(negedge clk);
    reset        = 1'b1;
    start        = 1'b0;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_release", 32'(busy), 32'd0);
    checkOutput("rst_no_writes", 32'(we_count), 32'd0);

    // Single word 0x12345678 on consecutive cycles.
    w0 = we_count;
    pulseStart(1);
    applyStimulus(4, 0, 8'h12, 8'h22, 1'b0, 40, -1, acc);
    checkOutput("single_accepted", 32'(acc), 32'd4);
    waitDone("single_done", 20);
    checkOutput("single_we_count", 32'(we_count - w0), 32'd1);
    checkOutput("single_word", obs_mem[0], 32'h12345678);
    checkOutput("single_cpu_reset", 32'(cpu_reset), 32'd1);

    // Two words with in_valid toggling, started from DONE.
    w0 = we_count;
    pulseStart(2);
    applyStimulus(8, 1, 8'hAA, 8'h01, 1'b0, 80, -1, acc);
    checkOutput("gaps_accepted", 32'(acc), 32'd8);
    waitDone("gaps_done", 20);
    checkOutput("gaps_we_count", 32'(we_count - w0), 32'd2);
    checkOutput("gaps_word0", obs_mem[0], 32'hAAABACAD);
    checkOutput("gaps_word1", obs_mem[1], 32'hAEAFB0B1);

    // Oversized request clamps to the full memory; random valid pattern.
    w0 = we_count;
    pulseStart(100);
    applyStimulus(256, 2, 8'h00, 8'h01, 1'b1, 3000, -1, acc);
    checkOutput("clamp_accepted", 32'(acc), 32'd256);
    waitDone("clamp_done", 20);
    checkOutput("clamp_we_count", 32'(we_count - w0), 32'd64);
    applyStimulus(8, 0, 8'h00, 8'h01, 1'b1, 10, -1, acc);
    checkOutput("after_done_accepted", 32'(acc), 32'd0);

    // Zero-length load from IDLE goes straight to DONE.
    holdReset(2);
    w0 = we_count;
    pulseStart(0);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_cpu_reset", 32'(cpu_reset), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("zero_we_count", 32'(we_count - w0), 32'd0);

    // Abort after two bytes of word 3, then restart with a stray start
    // pulsed mid-collect.
    w0 = we_count;
    pulseStart(5);
    applyStimulus(14, 2, 8'h00, 8'h01, 1'b1, 400, -1, acc);
    checkOutput("abort_accepted", 32'(acc), 32'd14);
    holdReset(2);
    checkOutput("abort_we_count", 32'(we_count - w0), 32'd3);
    checkOutput("abort_cpu_reset", 32'(cpu_reset), 32'd0);
    w0 = we_count;
    pulseStart(1);
    applyStimulus(4, 0, 8'hC0, 8'h01, 1'b0, 40, 2, acc);
    waitDone("restart_done", 20);
    checkOutput("restart_we_count", 32'(we_count - w0), 32'd1);
    checkOutput("restart_word", obs_mem[0], 32'hC0C1C2C3);

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the core's instruction fetch path: the PC and instruction ROM only read, and this block fills the 64 x 32-bit instruction memory.
- Accepts a byte stream over a valid/ready handshake and packs four bytes, MSB first, into each 32-bit instruction word.
- Writes each word to consecutive instruction-memory addresses starting at 0.
- Holds the processor in reset for the whole load and releases it when loading completes.

Parameters:
ADDR_W, 6, instruction-memory address width; matches the 6-bit PC.
DEPTH, 64, instruction-memory depth in words; equals 2**ADDR_W.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
start  input  1  begin a load; honoured only in IDLE or DONE.
nwords  input  ADDR_W+1  number of words to load; latched when start is accepted.
in_valid  input  1  in_data holds a valid byte.
in_data  input  8  program byte.
in_ready  output  1  loader will accept a byte this cycle.
we  output  1  instruction-memory write enable, one-cycle pulse per word.
waddr  output  ADDR_W  instruction-memory write address.
wdata  output  32  instruction word being written.
busy  output  1  a load is in progress.
done  output  1  last load completed; sticky until the next start.
cpu_reset  output  1  active-low reset to the core; 0 holds the core in reset.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, cpu_reset=0.
  - Internal byte counter and word counter are cleared.
- Reset mid-load aborts the load:
  - Any partially assembled word is discarded; no write occurs.
  - The core stays in reset (cpu_reset=0).
- States: IDLE, COLLECT, WRITE, DONE. All outputs are registered.
- IDLE: in_ready=0, busy=0, cpu_reset=0.
  - start=1 with nwords==0: next state DONE; no writes.
  - start=1 with nwords>0: latch len=min(nwords,DEPTH), waddr=0, byte count=0, word count=0.
  - Next state COLLECT with busy=1, in_ready=1.
- COLLECT: in_ready=1.
  - A byte is accepted on a rising edge where in_valid & in_ready.
  - On accept: wdata <= {wdata[23:0], in_data}, so the first byte lands in [31:24].
  - in_valid while in_ready=0 is ignored; no byte is consumed.
  - On acceptance of the 4th byte: next state WRITE, in_ready=0.
- WRITE: exactly one cycle.
  - we=1 with waddr/wdata stable for the whole cycle.
  - Next edge: waddr <= waddr+1, wrapping mod DEPTH (63 -> 0); word count +1.
  - If word count reaches len: next state DONE. Otherwise: next state COLLECT, byte count 0.
- Throughput: at most one word per 5 cycles (4 accept cycles + 1 write cycle).
- DONE:
  - done=1, busy=0, in_ready=0, we=0, cpu_reset=1, waddr=0.
  - start=1 begins a new load exactly as from IDLE.
  - On that start: done->0 and cpu_reset->0 on the same edge.
- start is ignored while in COLLECT or WRITE.
- nwords values > DEPTH are clamped to DEPTH. No wrap-around overwrite of address 0 occurs within one load.
- we is never asserted outside WRITE.
- cpu_reset is never 1 while busy=1.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1 and in_valid=1 -> all outputs 0, no we pulse; the first cycle after release is still IDLE.
- Single word: start with nwords=1, then bytes 0x12,0x34,0x56,0x78 on consecutive cycles -> one we pulse with waddr=0, wdata=0x12345678 in the cycle after the 4th byte. Next cycle: done=1, cpu_reset=1, busy=0.
- Backpressure and gaps: nwords=2, in_valid toggled 1,0,1,0..., bytes 0xAA..0xB1 -> writes addr0=0xAAABACAD and addr1=0xAEAFB0B1. in_ready=0 during WRITE; a byte presented then is held and accepted in the next COLLECT cycle.
- Clamp/full depth: nwords=100, 256 bytes streamed -> exactly 64 we pulses with addresses 0..63. Then done=1 and further bytes are not accepted (in_ready=0).
- Zero length: start with nwords=0 -> DONE next cycle, no we pulse, cpu_reset=1.
- Abort and restart: reset=0 after 2 bytes of word 3 -> no write of the partial word, cpu_reset=0. A new start with nwords=1 then writes addr0; a start pulsed during COLLECT has no effect.
